// File: rtl/seq_booth_mul_pkg.sv
// Shared constants, state encoding and Booth select codes for the sequential radix-4 multiplier.
package seq_booth_mul_pkg;

   localparam int DATA_W = 32;
   localparam int ITER   = 16;
   localparam int ACC_W  = DATA_W + 2;
   localparam int CNT_W  = 5;

   localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [2:0] {
      SEL_ZERO = 3'd0,
      SEL_PA   = 3'd1,
      SEL_NA   = 3'd2,
      SEL_P2A  = 3'd3,
      SEL_N2A  = 3'd4
   } booth_sel_e;

   // Two guard bits keep -2A representable even for the most negative A.
   function automatic logic [ACC_W-1:0] booth_pp(input booth_sel_e sel, input logic [DATA_W-1:0] a);
      logic [ACC_W-1:0] ext;
      ext = {{2{a[DATA_W-1]}}, a};
      case (sel)
         SEL_PA:  booth_pp = ext;
         SEL_NA:  booth_pp = -ext;
         SEL_P2A: booth_pp = ext << 1;
         SEL_N2A: booth_pp = -(ext << 1);
         default: booth_pp = '0;
      endcase
   endfunction

endpackage

// File: rtl/seq_booth_mul_recoder.sv
// Radix-4 Booth recoder: maps a multiplier bit triplet to a partial-product select code.
module booth_recoder
   import seq_booth_mul_pkg::*;
(
   input  logic [2:0] triplet,
   output logic [2:0] sel
);

   always_comb begin
      sel = SEL_ZERO;
      case (triplet)
         3'b001, 3'b010: sel = SEL_PA;
         3'b011:         sel = SEL_P2A;
         3'b100:         sel = SEL_N2A;
         3'b101, 3'b110: sel = SEL_NA;
         default:        sel = SEL_ZERO;
      endcase
   end

endmodule

// File: rtl/seq_booth_mul.sv
// Sequential 32x32 signed multiplier, one Booth bit-pair per clock, 64-bit product on hi/lo.
module seq_booth_mul
   import seq_booth_mul_pkg::*;
(
   input  logic                Clock,
   input  logic                clear,
   input  logic                start,
   input  logic [DATA_W-1:0]   multiplicand,
   input  logic [DATA_W-1:0]   multiplier,
   output logic [DATA_W-1:0]   hi,
   output logic [DATA_W-1:0]   lo,
   output logic                busy,
   output logic                finished
);

   logic [1:0]              state_reg;
   logic [CNT_W-1:0]        count_reg;
   logic [DATA_W-1:0]       mcand_reg;
   logic [ACC_W-1:0]        upper_reg;
   logic [DATA_W-1:0]       lower_reg;
   logic                    prev_reg;

   logic [2:0]              sel_code;
   logic [ACC_W-1:0]        pp;
   logic [ACC_W-1:0]        sum;
   logic [ACC_W+DATA_W-1:0] shifted;

   booth_recoder u_recoder (
      .triplet ({lower_reg[1:0], prev_reg}),
      .sel     (sel_code)
   );

   assign pp      = booth_pp(booth_sel_e'(sel_code), mcand_reg);
   assign sum     = upper_reg + pp;
   assign shifted = $signed({sum, lower_reg}) >>> 2;

   // The multiplier is consumed from the low word as the product shifts in from above.
   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
         mcand_reg <= '0;
         upper_reg <= '0;
         lower_reg <= '0;
         prev_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  mcand_reg <= multiplicand;
                  upper_reg <= '0;
                  lower_reg <= multiplier;
                  prev_reg  <= 1'b0;
                  count_reg <= '0;
                  state_reg <= ST_RUN;
               end
            end
            ST_RUN: begin
               // After the 16th pair one more edge retires RUN, so finished lands 17 edges after start.
               if (count_reg == ITER_CNT) begin
                  state_reg <= ST_DONE;
               end else begin
                  upper_reg <= shifted[ACC_W+DATA_W-1:DATA_W];
                  lower_reg <= shifted[DATA_W-1:0];
                  prev_reg  <= lower_reg[1];
                  count_reg <= count_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign hi       = upper_reg[DATA_W-1:0];
   assign lo       = lower_reg;
   assign busy     = (state_reg == ST_RUN);
   assign finished = (state_reg == ST_DONE);

endmodule
